// File: rtl/fpu_pkg.sv
// Shared types and constants for the single-precision multiply sequencer.
package fpu_pkg;

    // RISC-V fflags ordering, MSB first.
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    localparam logic [31:0] CANON_NAN = 32'h7FC00000;
    localparam logic [31:0] POS_INF   = 32'h7F800000;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single-precision operand classifier.
module fp_classify (
    input  logic [31:0] value,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan,
    output logic        is_snan
);

    logic [7:0]  exp_f;
    logic [22:0] man_f;

    // Field decode; a quiet NaN has the top mantissa bit set.
    always_comb begin
        exp_f   = value[30:23];
        man_f   = value[22:0];
        is_zero = (exp_f == '0) && (man_f == '0);
        is_inf  = (exp_f == '1) && (man_f == '0);
        is_nan  = (exp_f == '1) && (man_f != '0);
        is_snan = is_nan && !man_f[22];
    end

endmodule

// File: rtl/fmul_sequencer.sv
// Issue/retire controller wrapped around an external fmultiplier: holds operands,
// releases the multiplier reset for one operation, captures its strobe, and
// returns the product with tag and fflags, with timeout and flush recovery.
module fmul_sequencer
    import fpu_pkg::*;
#(
    parameter int unsigned TAG_W          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_z,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [4:0]       rsp_flags,
    output logic             rsp_timeout,
    output logic             busy,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    output logic             mul_rst,
    input  logic [31:0]      mul_z,
    input  logic             mul_stb
);

    localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t       state;
    logic [CNT_W-1:0] count;
    fflags_t          flags_q;
    logic             nv_q;
    logic             finite_q;

    logic a_zero, a_inf, a_nan, a_snan;
    logic b_zero, b_inf, b_nan, b_snan;
    logic nv_next;
    logic finite_next;
    logic of_hit;

    fp_classify u_cls_a (
        .value   (req_a),
        .is_zero (a_zero),
        .is_inf  (a_inf),
        .is_nan  (a_nan),
        .is_snan (a_snan)
    );

    fp_classify u_cls_b (
        .value   (req_b),
        .is_zero (b_zero),
        .is_inf  (b_inf),
        .is_nan  (b_nan),
        .is_snan (b_snan)
    );

    // Operand classification at accept time and overflow detection at capture time.
    always_comb begin
        nv_next     = a_snan || b_snan || (a_inf && b_zero) || (a_zero && b_inf);
        finite_next = !a_inf && !a_nan && !b_inf && !b_nan;
        of_hit      = (mul_z[30:0] == POS_INF[30:0]) && finite_q;
    end

    assign req_ready = (state == SEQ_IDLE);
    assign busy      = (state != SEQ_IDLE);
    assign rsp_flags = flags_q;

    // Sequencer state, multiplier handshake and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SEQ_IDLE;
            mul_rst     <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            flags_q     <= '0;
            rsp_z       <= '0;
            rsp_tag     <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            count       <= '0;
            nv_q        <= 1'b0;
            finite_q    <= 1'b0;
        end else if (flush) begin
            state       <= SEQ_IDLE;
            mul_rst     <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    mul_rst <= 1'b1;
                    if (req_valid) begin
                        mul_a    <= req_a;
                        mul_b    <= req_b;
                        rsp_tag  <= req_tag;
                        nv_q     <= nv_next;
                        finite_q <= finite_next;
                        count    <= '0;
                        mul_rst  <= 1'b0;
                        state    <= SEQ_RUN;
                    end
                end
                SEQ_RUN: begin
                    count <= count + 1'b1;
                    // A strobe arriving on the final timeout cycle still wins.
                    if (mul_stb) begin
                        rsp_z     <= mul_z;
                        flags_q   <= '{nv: nv_q, dz: 1'b0, of: of_hit, uf: 1'b0, nx: 1'b0};
                        rsp_valid <= 1'b1;
                        mul_rst   <= 1'b1;
                        state     <= SEQ_DONE;
                    end else if (count == CNT_LAST) begin
                        rsp_z       <= CANON_NAN;
                        flags_q     <= '0;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        mul_rst     <= 1'b1;
                        state       <= SEQ_DONE;
                    end
                end
                SEQ_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_timeout <= 1'b0;
                        state       <= SEQ_IDLE;
                    end
                end
                default: begin
                    state   <= SEQ_IDLE;
                    mul_rst <= 1'b1;
                end
            endcase
        end
    end

endmodule
